// File: rtl/divisor.sv
// Sequential restoring divider: unsigned DV / DR, one quotient bit per two clock cycles.
// Optional build macro DIV_ZERO_FLAG_EN adds the dz port and a fast divide-by-zero path.
module divisor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] DV,
    input  logic [WIDTH-1:0] DR,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_FLAG_EN
    output logic [WIDTH-1:0] remainder,
    output logic             dz
`else
    output logic [WIDTH-1:0] remainder
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        START = 3'd0,
        SHIFT = 3'd1,
        SUB   = 3'd2,
        DONE  = 3'd3,
        ZERO  = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    cnt;

    logic             ge_c;
    logic [WIDTH:0]   r_next_c;
    logic [WIDTH-1:0] q_next_c;

    // Trial subtraction; keep the partial remainder when the divisor does not fit.
    always_comb begin
        ge_c     = (r_reg >= {1'b0, d_reg});
        r_next_c = r_reg;
        if (ge_c) begin
            r_next_c = r_reg - {1'b0, d_reg};
        end
        q_next_c = {q_reg[WIDTH-1:1], ge_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= START;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz        <= 1'b0;
`endif
        end else begin
            case (state)
                START: begin
                    if (init) begin
                        r_reg <= '0;
                        q_reg <= DV;
                        d_reg <= DR;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                        dz    <= 1'b0;
                        if (DR == '0) begin
                            state <= ZERO;
                        end else begin
                            state <= SHIFT;
                        end
`else
                        state <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    {r_reg, q_reg} <= {r_reg[WIDTH-1:0], q_reg, 1'b0};
                    cnt            <= cnt - CW'(1);
                    state          <= SUB;
                end
                SUB: begin
                    r_reg <= r_next_c;
                    q_reg <= q_next_c;
                    if (cnt == '0) begin
                        quotient  <= q_next_c;
                        remainder <= r_next_c[WIDTH-1:0];
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= START;
                end
`ifdef DIV_ZERO_FLAG_EN
                // Divide-by-zero short cut: q_reg still holds the captured dividend.
                ZERO: begin
                    quotient  <= '1;
                    remainder <= q_reg;
                    dz        <= 1'b1;
                    done      <= 1'b1;
                    state     <= DONE;
                end
`endif
                default: begin
                    state <= START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor: vector table, hand-written handshake/reset sequences,
// exhaustive WIDTH=4 and random WIDTH=8 runs against an arithmetic reference model.
module tb_divisor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       init4, busy4, done4;
    logic [3:0] dv4, dr4, q4, r4;
    logic       init8, busy8, done8;
    logic [7:0] dv8, dr8, q8, r8;
`ifdef DIV_ZERO_FLAG_EN
    logic       dz4, dz8;
`endif

    int total = 0;
    int bad   = 0;

    divisor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .init(init4), .DV(dv4), .DR(dr4),
        .busy(busy4), .done(done4), .quotient(q4),
`ifdef DIV_ZERO_FLAG_EN
        .remainder(r4), .dz(dz4)
`else
        .remainder(r4)
`endif
    );

    divisor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .init(init8), .DV(dv8), .DR(dr8),
        .busy(busy8), .done(done8), .quotient(q8),
`ifdef DIV_ZERO_FLAG_EN
        .remainder(r8), .dz(dz8)
`else
        .remainder(r8)
`endif
    );

    typedef struct {
        int dv;
        int dr;
        int q;
        int r;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; DR=0 yields all ones / dividend.
    function automatic void ref_div(input int w, input int dv, input int dr,
                                    output int eq, output int er);
        if (dr == 0) begin
            eq = (1 << w) - 1;
            er = dv;
        end else begin
            eq = dv / dr;
            er = dv % dr;
        end
    endfunction

    // One complete operation from START: accept, wait for done, check results and timing.
    task automatic op(input bit w8, input int dv, input int dr, input int eq, input int er);
        int    w, explat, lat;
        bit    seen;
        string tag;
        w      = w8 ? 8 : 4;
        explat = 2 * w;
`ifdef DIV_ZERO_FLAG_EN
        if (dr == 0) explat = 1;
`endif
        tag = $sformatf("w%0d %0d/%0d", w, dv, dr);
        @(negedge clk);
        if (w8) begin
            init8 = 1'b1; dv8 = 8'(dv); dr8 = 8'(dr);
        end else begin
            init4 = 1'b1; dv4 = 4'(dv); dr4 = 4'(dr);
        end
        @(posedge clk); #1;
        init4 = 1'b0; init8 = 1'b0;
        dv4 = 4'($urandom); dr4 = 4'($urandom); dv8 = 8'($urandom); dr8 = 8'($urandom);
        chk({tag, " busy"}, 32'(w8 ? busy8 : busy4), 32'd1);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            if ((w8 ? done8 : done4) === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) begin
            chk({tag, " done timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, " latency"}, 32'(lat), 32'(explat));
            chk({tag, " quotient"}, 32'(w8 ? q8 : {4'd0, q4}), 32'(eq));
            chk({tag, " remainder"}, 32'(w8 ? r8 : {4'd0, r4}), 32'(er));
`ifdef DIV_ZERO_FLAG_EN
            chk({tag, " dz"}, 32'(w8 ? dz8 : dz4), 32'(dr == 0));
`endif
            @(posedge clk); #1;
            chk({tag, " done width"}, 32'(w8 ? done8 : done4), 32'd0);
            chk({tag, " busy low"}, 32'(w8 ? busy8 : busy4), 32'd0);
        end
    endtask

    initial begin
        int eq, er, d1, d2, n;
        int q1, r1, q2, r2;
        bit seen;

        rst = 1'b1;
        init4 = 1'b0; dv4 = '0; dr4 = '0;
        init8 = 1'b0; dv8 = '0; dr8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy4), 32'd0);
        chk("reset done", 32'(done4), 32'd0);
        chk("reset quotient", 32'(q4), 32'd0);
        chk("reset remainder", 32'(r4), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("reset dz", 32'(dz4), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{13, 3, 4, 1};
        vecs[1] = '{15, 1, 15, 0};
        vecs[2] = '{5, 7, 0, 5};
        vecs[3] = '{0, 9, 0, 0};
        vecs[4] = '{9, 0, 15, 9};
        vecs[5] = '{6, 2, 3, 0};
        vecs[6] = '{12, 5, 2, 2};
        vecs[7] = '{7, 7, 1, 0};
        vecs[8] = '{14, 4, 3, 2};
        for (int i = 0; i < 9; i++) begin
            op(1'b0, vecs[i].dv, vecs[i].dr, vecs[i].q, vecs[i].r);
        end

        // Reset mid-operation at e4: outputs cleared, no done pulse, then a clean restart.
        @(negedge clk);
        init4 = 1'b1; dv4 = 4'd13; dr4 = 4'd3;
        @(posedge clk); #1;
        init4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst busy", 32'(busy4), 32'd0);
        chk("midrst done", 32'(done4), 32'd0);
        chk("midrst quotient", 32'(q4), 32'd0);
        chk("midrst remainder", 32'(r4), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1 || busy4 === 1'b1) seen = 1'b1;
        end
        chk("midrst idle after", 32'(seen), 32'd0);
        op(1'b0, 10, 4, 2, 2);

        // init held high: back-to-back accepts 2*WIDTH+2 edges apart, operands swapped mid-op.
        @(negedge clk);
        init4 = 1'b1; dv4 = 4'd12; dr4 = 4'd5;
        @(posedge clk); #1;
        chk("hold busy", 32'(busy4), 32'd1);
        dv4 = 4'd7; dr4 = 4'd7;
        d1 = 0; d2 = 0; q1 = 0; r1 = 0; q2 = 0; r2 = 0;
        for (int k = 1; k <= 40 && d2 == 0; k++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1) begin
                if (d1 == 0) begin
                    d1 = k; q1 = int'(q4); r1 = int'(r4);
                end else begin
                    d2 = k; q2 = int'(q4); r2 = int'(r4);
                end
            end
        end
        init4 = 1'b0;
        chk("hold first done edge", 32'(d1), 32'd8);
        chk("hold second done edge", 32'(d2), 32'd18);
        chk("hold q1", 32'(q1), 32'd2);
        chk("hold r1", 32'(r1), 32'd2);
        chk("hold q2", 32'(q2), 32'd1);
        chk("hold r2", 32'(r2), 32'd0);
        repeat (2) @(posedge clk);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ref_div(4, a, b, eq, er);
                op(1'b0, a, b, eq, er);
            end
        end

        n = 0;
        while (n < 800) begin
            int a, b;
            a = int'($urandom_range(255, 0));
            b = (n % 50 == 0) ? 0 : int'($urandom_range(255, 1));
            ref_div(8, a, b, eq, er);
            op(1'b1, a, b, eq, er);
            n++;
        end
        op(1'b1, 255, 1, 255, 0);
        op(1'b1, 1, 255, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
